// File: rtl/shift_unit_if.sv
// Request/result bundle for shift_unit.
//   master : requester side; drives start, A, shamt, LR, LA and observes ready, done, Y, C, Z
//   slave  : shift_unit side; the mirror image of master
interface shift_unit_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [SHW-1:0]   shamt;
  logic             LR;
  logic             LA;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] Y;
  logic             C;
  logic             Z;

  modport master (
    output start, A, shamt, LR, LA,
    input  ready, done, Y, C, Z
  );

  modport slave (
    input  start, A, shamt, LR, LA,
    output ready, done, Y, C, Z
  );
endinterface

// File: rtl/shift_unit.sv
// Iterative barrel-free shifter: one bit per clock, left logical, right logical
// or right arithmetic, with a start/ready/done handshake.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   bus   : shift_unit_if.slave
//           start/A/shamt/LR/LA in (captured when ready=1 and start=1)
//           ready (IDLE), done (one-cycle pulse), Y result, C last bit out,
//           Z = (Y == 0), meaningful while done
module shift_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input logic          clk,
  input logic          rst,
  shift_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] y_q;
  logic             c_q;
  logic [SHW-1:0]   cnt_q;
  logic             lr_q;
  logic             la_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on accept, one 1-bit shift per SHIFT edge while cnt != 0
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= '0;
      c_q   <= 1'b0;
      cnt_q <= '0;
      lr_q  <= 1'b0;
      la_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            y_q   <= bus.A;
            cnt_q <= bus.shamt;
            lr_q  <= bus.LR;
            la_q  <= bus.LA;
            c_q   <= 1'b0;
          end
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - SHW'(1);
            if (!lr_q) begin
              y_q <= {y_q[WIDTH-2:0], 1'b0};
              c_q <= y_q[WIDTH-1];
            end else begin
              // Fill bit is the sign for arithmetic, zero for logical
              y_q <= {la_q & y_q[WIDTH-1], y_q[WIDTH-1:1]};
              c_q <= y_q[0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.Y     = y_q;
  assign bus.C     = c_q;
  assign bus.Z     = (y_q == '0);

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit (WIDTH=8): directed corner cases plus
// randomized operations checked against an arithmetic reference model.
module tb_shift_unit;

  localparam int unsigned W = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  shift_unit_if #(.WIDTH(W)) bus ();

  shift_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result {C, Y} computed from the shift definitions directly
  function automatic logic [W:0] model(input logic [W-1:0] a, input int n,
                                       input logic lr, input logic la);
    logic [W-1:0] y;
    logic         c;
    if (n == 0) begin
      y = a;
      c = 1'b0;
    end else if (!lr) begin
      y = W'(a << n);
      c = a[W-n];
    end else if (!la) begin
      y = a >> n;
      c = a[n-1];
    end else begin
      y = W'($signed(a) >>> n);
      c = a[n-1];
    end
    return {c, y};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation: accept, wait for done (bounded), check result/latency/handshake
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [2:0] n,
                        input logic lr, input logic la,
                        input logic [W-1:0] ey, input logic ec, input bit poke);
    int edges;
    bit seen;
    @(negedge clk);
    chk({tag, "_ready_idle"}, 32'(bus.ready), 32'd1);
    bus.start = 1'b1;
    bus.A     = a;
    bus.shamt = n;
    bus.LR    = lr;
    bus.LA    = la;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 40) begin
      if (poke) begin
        bus.start = 1'($urandom);
        bus.A     = W'($urandom);
        bus.shamt = 3'($urandom);
        bus.LR    = 1'($urandom);
        bus.LA    = 1'($urandom);
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
      else chk({tag, "_ready_busy"}, 32'(bus.ready), 32'd0);
    end
    bus.start = 1'b0;
    chk({tag, "_latency"}, 32'(edges), 32'(n) + 32'd1);
    chk({tag, "_Y"}, 32'(bus.Y), 32'(ey));
    chk({tag, "_C"}, 32'(bus.C), 32'(ec));
    chk({tag, "_Z"}, 32'(bus.Z), 32'(ey == '0));
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_ready_back"}, 32'(bus.ready), 32'd1);
    chk({tag, "_Y_hold"}, 32'(bus.Y), 32'(ey));
    chk({tag, "_C_hold"}, 32'(bus.C), 32'(ec));
  endtask

  initial begin
    logic [W:0]   r;
    logic [W-1:0] a;
    logic [2:0]   n;
    logic         lr;
    logic         la;
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.A     = 8'hA5;
    bus.shamt = 3'd3;
    bus.LR    = 1'b0;
    bus.LA    = 1'b0;

    // Reset with start held high: start must be dropped
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_Y", 32'(bus.Y), 32'd0);
    chk("rst_C", 32'(bus.C), 32'd0);
    chk("rst_Z", 32'(bus.Z), 32'd1);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_idle", 32'(bus.ready), 32'd1);

    // Directed corner cases
    run_op("ll_81_1", 8'h81, 3'd1, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0);
    run_op("rl_96_3", 8'h96, 3'd3, 1'b1, 1'b0, 8'h12, 1'b1, 1'b0);
    run_op("ra_96_3", 8'h96, 3'd3, 1'b1, 1'b1, 8'hF2, 1'b1, 1'b0);
    run_op("ra_80_7", 8'h80, 3'd7, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    run_op("rl_80_7", 8'h80, 3'd7, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
    run_op("ll_01_7", 8'h01, 3'd7, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0);
    run_op("ll_5A_0", 8'h5A, 3'd0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0);
    run_op("ra_5A_0", 8'h5A, 3'd0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
    run_op("ll_80_1", 8'h80, 3'd1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    // Start and operand changes during SHIFT must not disturb the result
    run_op("poke_96", 8'h96, 3'd5, 1'b1, 1'b1, 8'hFC, 1'b1, 1'b1);

    // Reset two edges into a shamt=6 operation
    @(negedge clk);
    chk("abort_ready", 32'(bus.ready), 32'd1);
    bus.start = 1'b1;
    bus.A     = 8'hC3;
    bus.shamt = 3'd6;
    bus.LR    = 1'b1;
    bus.LA    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready_after", 32'(bus.ready), 32'd1);
    chk("abort_Y", 32'(bus.Y), 32'd0);
    chk("abort_C", 32'(bus.C), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("abort_no_done", 32'(bus.done), 32'd0);
    end
    run_op("after_abort", 8'h3C, 3'd2, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      a  = W'($urandom);
      n  = 3'($urandom_range(0, 7));
      lr = 1'($urandom);
      la = 1'($urandom);
      r  = model(a, int'(n), lr, la);
      run_op($sformatf("rnd%0d", i), a, n, lr, la, r[W-1:0], r[W], bit'(i % 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data width in bits (power of two, >= 4).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), meaning shift-amount width.
REQ-003 SHALL have port clk  input  1  rising-edge clock; the block uses one clock only.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port start  input  1  request; sampled only when ready=1.
REQ-006 SHALL have port A  input  WIDTH  operand, captured on the accepted start.
REQ-007 SHALL have port shamt  input  SHW  shift count 0..WIDTH-1, captured on the accepted start.
REQ-008 SHALL have port LR  input  1  direction: 0 = left, 1 = right; captured on the accepted start.
REQ-009 SHALL have port LA  input  1  right-shift kind: 0 = logical, 1 = arithmetic; ignored when LR=0; captured on the accepted start.
REQ-010 SHALL have port ready  output  1  high in IDLE only.
REQ-011 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-012 SHALL have port Y  output  WIDTH  result register.
REQ-013 SHALL have port C  output  1  last bit shifted out.
REQ-014 SHALL have port Z  output  1  high when Y == 0; qualified by done.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE; all outputs registered or decoded from state.
REQ-016 SHALL, in IDLE with start=1, load A into Y, shamt into a down-counter cnt, latch LR/LA, clear C, and go to SHIFT on that edge.
REQ-017 SHALL, in SHIFT with cnt != 0, perform exactly one 1-bit shift per edge and decrement cnt.
REQ-018 SHALL, in SHIFT with cnt == 0, go to DONE without shifting.
REQ-019 SHALL implement the modes as follows: left logical (LR=0): Y <= {Y[WIDTH-2:0],0}, C <= Y[WIDTH-1].
REQ-020 SHALL implement right logical (LR=1, LA=0) as Y <= {0,Y[WIDTH-1:1]}, C <= Y[0].
REQ-021 SHALL implement right arithmetic (LR=1, LA=1) as Y <= {Y[WIDTH-1],Y[WIDTH-1:1]}, C <= Y[0]; sign preserved each step.
REQ-022 SHALL have latency: done high in the cycle following edge k+N+1, where k is the accepting edge and N is shamt; shamt=0 gives done after 1 edge, with Y=A and C=0.
REQ-023 SHALL go from DONE to IDLE unconditionally on the next edge; done is high for exactly one cycle.
REQ-024 SHALL hold Y, C and Z stable from DONE until the next accepted start.
REQ-025 SHALL ignore start while ready=0 (SHIFT/DONE); no queuing; in-flight operand, count and mode are unaffected.
REQ-026 SHALL not sample start in DONE; back-to-back operations are therefore accepted no earlier than 1 cycle after done.
REQ-027 SHALL use operand values from the accepting edge only; changes to A, shamt, LR or LA afterward have no effect.
REQ-028 SHALL keep cnt width at SHW; no wrap, since cnt only decrements while nonzero.

Reset
REQ-029 SHALL, with rst=1 at a clock edge, force state=IDLE, Y=0, C=0, cnt=0, done=0, ready=1 (Z=1), regardless of state.
REQ-030 SHALL give rst priority over start on the same edge; that start is dropped.
REQ-031 SHALL, on reset mid-SHIFT, abort the operation with no done pulse; the next start after rst deasserts behaves normally.

Verification (WIDTH=8)
REQ-032 SHALL cover: left logical, A=0x81, shamt=1 -> done after 2 edges, Y=0x02, C=1, Z=0.
REQ-033 SHALL cover: right logical, A=0x96, shamt=3 -> done after 4 edges, Y=0x12, C=1; right arithmetic, same inputs -> Y=0xF2, C=1.
REQ-034 SHALL cover: right arithmetic, A=0x80, shamt=7 -> Y=0xFF, C=0; right logical, A=0x80, shamt=7 -> Y=0x01, C=0; left logical, A=0x01, shamt=7 -> Y=0x80, C=0.
REQ-035 SHALL cover: shamt=0, A=0x5A, any mode -> done after 1 edge, Y=0x5A, C=0; left logical, A=0x80, shamt=1 -> Y=0x00, Z=1, C=1.
REQ-036 SHALL cover: start pulsed with new A during SHIFT -> ignored; the first result is unchanged; ready returns 1 one cycle after done.
REQ-037 SHALL cover: rst asserted 2 edges into a shamt=6 operation -> next cycle ready=1, Y=0, no done; a following operation completes correctly.
